// File: rtl/result_demux.sv
// result_demux
//   Receiving end of the 3-bit dice/traffic-light multiplexed bus. Splits the
//   bus into a dice value and red/amber/green lamp drives. It checks each stream
//   for legality and keeps saturating roll and error counters.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   sel         bus source: 0 = dice, 1 = traffic lights
//   result      bus value: dice binary value, or {red, amber, green}
//   dice_val    last legal dice value (0 = none yet)
//   roll_strobe one-cycle pulse when a new roll is accepted
//   red/amber/green lamp drives from the last legal traffic code
//   synced      traffic tracker locked to the sequence
//   dice_error  one-cycle pulse on an illegal dice code
//   seq_error   one-cycle pulse on an illegal or out-of-order traffic code
//   roll_count  accepted rolls, saturating
//   err_count   dice_error + seq_error events, saturating
//   trk_state   debug view of the traffic tracker state register
//
// Timing: a bus value present at clock edge k is captured into s_q/r_q at
// edge k. It is decoded into the registered outputs at edge k+1.
module result_demux #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [2:0]       result,
    output logic [2:0]       dice_val,
    output logic             roll_strobe,
    output logic             red,
    output logic             amber,
    output logic             green,
    output logic             synced,
    output logic             dice_error,
    output logic             seq_error,
    output logic [CNT_W-1:0] roll_count,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       trk_state
);

    typedef enum logic [2:0] {
        T_UNSYNC = 3'd0,
        T_RED    = 3'd1,
        T_RA     = 3'd2,
        T_GREEN  = 3'd3,
        T_AMBER  = 3'd4
    } trk_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Input stage and internal state
    logic       s_q;
    logic [2:0] r_q;
    logic       prev_sel;
    logic       dice_primed;
    // live goes high on the first edge after reset release. Until then, s_q/r_q
    // hold reset values rather than a real bus sample. Those values are not
    // decoded.
    logic       live;
    trk_t       state;

    // Next-state values
    trk_t             state_n;
    logic             primed_n;
    logic [2:0]       dice_val_n;
    logic [2:0]       lamps_n;
    logic             synced_n;
    logic             roll_strobe_n;
    logic             dice_error_n;
    logic             seq_error_n;
    logic [CNT_W-1:0] roll_count_n;
    logic [CNT_W-1:0] err_count_n;

    // Working signals
    logic switched;
    trk_t cur;
    logic primed_cur;
    trk_t code_st;

    // Maps a traffic code to its state. Any illegal code maps to T_UNSYNC.
    function automatic trk_t code_to_state(input logic [2:0] code);
        case (code)
            3'b100:  return T_RED;
            3'b110:  return T_RA;
            3'b001:  return T_GREEN;
            3'b010:  return T_AMBER;
            default: return T_UNSYNC;
        endcase
    endfunction

    function automatic trk_t successor(input trk_t st);
        case (st)
            T_RED:   return T_RA;
            T_RA:    return T_GREEN;
            T_GREEN: return T_AMBER;
            T_AMBER: return T_RED;
            default: return T_UNSYNC;
        endcase
    endfunction

    always_comb begin
        // A source switch acts on the current cycle's sample. The tracker and
        // the dice priming are cleared before the sample is decoded under the
        // new source.
        switched      = (s_q != prev_sel);
        cur           = switched ? T_UNSYNC : state;
        primed_cur    = switched ? 1'b0 : dice_primed;
        code_st       = code_to_state(r_q);

        state_n       = state;
        primed_n      = dice_primed;
        dice_val_n    = dice_val;
        lamps_n       = {red, amber, green};
        synced_n      = synced;
        roll_strobe_n = 1'b0;
        dice_error_n  = 1'b0;
        seq_error_n   = 1'b0;
        roll_count_n  = roll_count;
        err_count_n   = err_count;

        if (live) begin
            state_n  = cur;
            primed_n = primed_cur;
            // Leaving traffic mode drops the lock indication.
            if (switched && !s_q) begin
                synced_n = 1'b0;
            end

            if (!s_q) begin
                if (r_q != 3'd0 && r_q != 3'd7) begin
                    if (primed_cur && r_q != dice_val) begin
                        roll_strobe_n = 1'b1;
                    end
                    dice_val_n = r_q;
                    primed_n   = 1'b1;
                end else begin
                    dice_error_n = 1'b1;
                end
            end else begin
                if (code_st == T_UNSYNC) begin
                    // Illegal code: drop lock; the lamps keep their last value.
                    seq_error_n = 1'b1;
                    state_n     = T_UNSYNC;
                    synced_n    = 1'b0;
                end else begin
                    // A legal code always becomes the new state. It is an error
                    // only when the tracker was locked and the code is neither
                    // the current state nor its successor.
                    if (cur != T_UNSYNC && code_st != cur && code_st != successor(cur)) begin
                        seq_error_n = 1'b1;
                    end
                    state_n  = code_st;
                    synced_n = 1'b1;
                    lamps_n  = r_q;
                end
            end

            if (roll_strobe_n && roll_count != CNT_MAX) begin
                roll_count_n = roll_count + 1'b1;
            end
            if ((dice_error_n || seq_error_n) && err_count != CNT_MAX) begin
                err_count_n = err_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q         <= 1'b0;
            r_q         <= 3'd0;
            prev_sel    <= 1'b0;
            live        <= 1'b0;
            dice_primed <= 1'b0;
            state       <= T_UNSYNC;
            dice_val    <= 3'd0;
            red         <= 1'b0;
            amber       <= 1'b0;
            green       <= 1'b0;
            synced      <= 1'b0;
            roll_strobe <= 1'b0;
            dice_error  <= 1'b0;
            seq_error   <= 1'b0;
            roll_count  <= '0;
            err_count   <= '0;
        end else begin
            s_q         <= sel;
            r_q         <= result;
            prev_sel    <= s_q;
            live        <= 1'b1;
            dice_primed <= primed_n;
            state       <= state_n;
            dice_val    <= dice_val_n;
            red         <= lamps_n[2];
            amber       <= lamps_n[1];
            green       <= lamps_n[0];
            synced      <= synced_n;
            roll_strobe <= roll_strobe_n;
            dice_error  <= dice_error_n;
            seq_error   <= seq_error_n;
            roll_count  <= roll_count_n;
            err_count   <= err_count_n;
        end
    end

    assign trk_state = state;

endmodule
